// File: rtl/narrow_pkg.sv
// Shared types and constants for the narrow_pack datapath.
// Default widths, saturation limits and the packer state encoding.
package narrow_pkg;

    localparam int IN_WIDTH_DEF  = 32;
    localparam int OUT_WIDTH_DEF = 16;

    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_narrow.sv
// Combinational signed narrowing with saturation to the halfword range.
// A word fits when every bit from the halfword sign bit upward agrees.
module sat_narrow
    import narrow_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic [IN_WIDTH-1:0]  word,
    output logic [OUT_WIDTH-1:0] halfword,
    output logic                 sat
);

    logic [IN_WIDTH-OUT_WIDTH:0] upper;

    assign upper = word[IN_WIDTH-1:OUT_WIDTH-1];
    assign sat   = !((&upper) || !(|upper));

    always_comb begin
        halfword = word[OUT_WIDTH-1:0];
        if (sat) begin
            halfword = word[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/narrow_pack.sv
// Narrows signed input words and packs two halfwords per output word,
// with flush for a lone low half and saturation statistics.
module narrow_pack
    import narrow_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*OUT_WIDTH-1:0] out_data,
    output logic [1:0]             out_mask,
    input  logic                   sat_clear,
    output logic                   sat_sticky,
    output logic [15:0]            sat_count
);

    state_t state, state_next;

    logic [OUT_WIDTH-1:0] low_half;
    logic [OUT_WIDTH-1:0] narrowed;
    logic                 narrowed_sat;
    logic                 accept;
    logic                 transfer;
    logic                 sat_hit;
    logic                 load_low;
    logic                 load_pair;
    logic                 load_flush;

    sat_narrow #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat_narrow (
        .word     (in_data),
        .halfword (narrowed),
        .sat      (narrowed_sat)
    );

    assign out_valid = (state == FULL);
    assign in_ready  = (state != FULL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;
    assign sat_hit   = accept && narrowed_sat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // An accept always wins over flush in HALF, so flush only completes a lone low half.
    always_comb begin
        state_next = state;
        load_low   = 1'b0;
        load_pair  = 1'b0;
        load_flush = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next = HALF;
                    load_low   = 1'b1;
                end
            end
            HALF: begin
                if (accept) begin
                    state_next = FULL;
                    load_pair  = 1'b1;
                end else if (flush) begin
                    state_next = FULL;
                    load_flush = 1'b1;
                end
            end
            FULL: begin
                if (transfer) begin
                    if (accept) begin
                        state_next = HALF;
                        load_low   = 1'b1;
                    end else begin
                        state_next = EMPTY;
                    end
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            low_half <= '0;
            out_data <= '0;
            out_mask <= 2'b00;
        end else begin
            if (load_low) begin
                low_half <= narrowed;
            end
            if (load_pair) begin
                out_data <= {narrowed, low_half};
                out_mask <= 2'b11;
            end else if (load_flush) begin
                out_data <= {{OUT_WIDTH{1'b0}}, low_half};
                out_mask <= 2'b01;
            end
        end
    end

    // A clear in the same cycle as a saturating accept still counts that accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_sticky <= 1'b0;
            sat_count  <= 16'd0;
        end else if (sat_clear) begin
            sat_sticky <= sat_hit;
            sat_count  <= sat_hit ? 16'd1 : 16'd0;
        end else if (sat_hit) begin
            sat_sticky <= 1'b1;
            if (sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/narrow_pack.md
NARROW_PACK -- requirements
Module: narrow_pack

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of the signed input word.
REQ-002 SHALL have parameter OUT_WIDTH, default 16, width of each narrowed signed halfword; IN_WIDTH > OUT_WIDTH.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, input word offered.
REQ-006 SHALL have port in_ready, output, 1, block accepts input this cycle.
REQ-007 SHALL have port in_data, input, IN_WIDTH, signed word to narrow.
REQ-008 SHALL have port flush, input, 1, emit a held partial word.
REQ-009 SHALL have port out_valid, output, 1, packed word available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes word.
REQ-011 SHALL have port out_data, output, 2*OUT_WIDTH, packed pair; first-accepted halfword in the low half.
REQ-012 SHALL have port out_mask, output, 2, bit0/bit1 = low/high half valid.
REQ-013 SHALL have port sat_clear, input, 1, zero saturation statistics.
REQ-014 SHALL have port sat_sticky, output, 1, some accepted word saturated since reset/clear.
REQ-015 SHALL have port sat_count, output, 16, number of saturated accepted words.

Function
REQ-016 Accept occurs when in_valid and in_ready are both 1; transfer out occurs when out_valid and out_ready are both 1.
REQ-017 Narrowing: word fits when in_data[IN_WIDTH-1:OUT_WIDTH-1] are all equal; result = in_data[OUT_WIDTH-1:0].
REQ-018 Non-fitting word saturates to +max (0x7FFF at default) when in_data MSB is 0, to min (0x8000) when MSB is 1.
REQ-019 Fitting words round-trip: sign-extending the result to IN_WIDTH reproduces in_data exactly.
REQ-020 States: EMPTY (no half held), HALF (low half held), FULL (packed word presented).
REQ-021 EMPTY: accept -> HALF, result stored in low half; flush ignored.
REQ-022 HALF: accept -> FULL, result stored in high half, out_mask=2'b11.
REQ-023 HALF: flush with no accept -> FULL, high half = 0, out_mask=2'b01; flush together with accept -> normal 2'b11 completion, flush discarded.
REQ-024 FULL: transfer without accept -> EMPTY; transfer with accept -> HALF holding new low half; no transfer -> stay, out_data/out_mask stable.
REQ-025 in_ready = (state != FULL) or out_ready; out_valid = (state == FULL); flush ignored in FULL.
REQ-026 Latency: out_valid asserts the cycle after the completing accept or flush; sustained throughput one input per cycle.
REQ-027 Each saturated accept sets sat_sticky and increments sat_count, which holds at 0xFFFF.
REQ-028 sat_clear zeroes both; sat_clear with a saturating accept in the same cycle yields sat_count=1, sat_sticky=1.

Reset
REQ-029 reset_n low SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_mask=0, sat_sticky=0, sat_count=0; in_ready=1 after release.
REQ-030 Reset mid-word SHALL discard any held halfword; no partial word emitted afterwards.

Structure
REQ-031 Package narrow_pkg SHALL hold the state enum, default widths, and SAT_MAX/SAT_MIN constants.
REQ-032 Combinational narrowing/saturation SHALL be sub-module sat_narrow (inputs word, outputs halfword and sat flag); narrow_pack holds FSM, packing registers, counters.

Verification
REQ-033 Accept 0x00001234 then 0xFFFF8001 -> one word 0x80011234, mask 2'b11, sat_count 0.
REQ-034 Accept 0x00012345 then 0x80000000 -> word 0x80007FFF, sat_count 2, sat_sticky 1.
REQ-035 Accept 0x00000042, pulse flush -> word 0x00000042, mask 2'b01; flush in EMPTY -> no output.
REQ-036 out_ready held 0 with in_valid streaming -> in_ready 0 in FULL, out_data stable; then out_ready=1 with in_valid -> transfer plus accept same cycle, state HALF.
REQ-037 Assert reset_n low while HALF -> out_valid 0 immediately; after release two accepts produce word from new data only.
REQ-038 sat_clear coincident with saturating accept -> sat_count 1; 65536 saturating accepts -> sat_count stays 0xFFFF.
